// File: rtl/sum_pipe_param.sv
// -----------------------------------------------------------------------------
// sum_pipe_param
//
// Pipelined WIDTH-bit adder/subtractor. The operation is cut into
// NSEG = WIDTH/SEG segments and each segment is resolved in its own register
// stage. The carry between segments always passes through a register.
//
// Each internal stage holds one working word per operand:
//   a_q : resolved sum segments rotated in at the top, with the not yet
//         consumed A segments underneath. The segment to resolve next is
//         always at bits [SEG-1:0].
//   b_q : B' rotated the same way, so its next segment is also at [SEG-1:0].
// After NSEG rotations the A word holds the complete sum in natural order.
//
// Ports
//   clk       rising-edge clock
//   reset_L   synchronous active-low reset, has priority over stall
//   in_valid  operands on this cycle are valid
//   op_sub    0: A+B+cin   1: A-B-cin (cin acts as borrow-in)
//   cin       carry-in / borrow-in
//   data_A    operand A (WIDTH bits)
//   data_B    operand B (WIDTH bits)
//   stall     1 holds every register, outputs included
//   out_valid out_sum/cout/ovf are valid
//   out_sum   result modulo 2^WIDTH
//   cout      carry out of the MSB (sub mode: 1 = no borrow)
//   ovf       signed overflow
// -----------------------------------------------------------------------------
module sum_pipe_param #(
   parameter int WIDTH = 16,
   parameter int SEG   = 4
) (
   input  logic             clk,
   input  logic             reset_L,
   input  logic             in_valid,
   input  logic             op_sub,
   input  logic             cin,
   input  logic [WIDTH-1:0] data_A,
   input  logic [WIDTH-1:0] data_B,
   input  logic             stall,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NSEG  = WIDTH / ((SEG > 0) ? SEG : 1);
   // Number of internal stages in front of the output stage (at least one
   // array entry so the declarations stay legal when NSEG is 1).
   localparam int NPIPE = (NSEG > 1) ? (NSEG - 1) : 1;

   // Reject parameter sets that cannot be segmented.
   if (SEG < 1) begin : g_seg_too_small
      $error("sum_pipe_param: SEG must be at least 1");
   end else if ((WIDTH % SEG) != 0) begin : g_width_not_multiple
      $error("sum_pipe_param: WIDTH must be a multiple of SEG");
   end

   // One segment of the ripple: SEG-bit sum plus carry in bit SEG.
   function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] a,
                                            input logic [SEG-1:0] b,
                                            input logic           c);
      return {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, c};
   endfunction

   // Drop the consumed low segment of a word and insert a new segment at the top.
   function automatic logic [WIDTH-1:0] rot_in(input logic [WIDTH-1:0] word,
                                               input logic [SEG-1:0]   seg);
      logic [WIDTH+SEG-1:0] tmp;
      tmp = {seg, word} >> SEG;
      return tmp[WIDTH-1:0];
   endfunction

   logic [WIDTH-1:0] a_q [NPIPE];
   logic [WIDTH-1:0] a_d [NPIPE];
   logic [WIDTH-1:0] b_q [NPIPE];
   logic [WIDTH-1:0] b_d [NPIPE];
   logic             c_q [NPIPE];
   logic             c_d [NPIPE];
   logic             v_q [NPIPE];
   logic             v_d [NPIPE];

   logic [WIDTH-1:0] sum_q,   sum_d;
   logic             cout_q,  cout_d;
   logic             ovf_q,   ovf_d;
   logic             valid_q, valid_d;

   // Next-state for every stage: resolve one segment per stage from its registered inputs.
   always_comb begin
      logic [WIDTH-1:0] st_a [NSEG];
      logic [WIDTH-1:0] st_b [NSEG];
      logic             st_c [NSEG];
      logic             st_v [NSEG];
      logic [SEG:0]     r;
      logic [SEG-1:0]   a_seg;
      logic [SEG-1:0]   b_seg;

      for (int i = 0; i < NSEG; i++) begin
         st_a[i] = '0;
         st_b[i] = '0;
         st_c[i] = 1'b0;
         st_v[i] = 1'b0;
      end
      for (int i = 0; i < NPIPE; i++) begin
         a_d[i] = '0;
         b_d[i] = '0;
         c_d[i] = 1'b0;
         v_d[i] = 1'b0;
      end

      // Stage inputs: ports for the first segment, previous registers otherwise.
      st_a[0] = data_A;
      st_b[0] = data_B ^ {WIDTH{op_sub}};
      st_c[0] = cin ^ op_sub;
      st_v[0] = in_valid;
      for (int i = 1; i < NSEG; i++) begin
         st_a[i] = a_q[i-1];
         st_b[i] = b_q[i-1];
         st_c[i] = c_q[i-1];
         st_v[i] = v_q[i-1];
      end

      for (int i = 0; i < NSEG - 1; i++) begin
         r      = seg_add(st_a[i][SEG-1:0], st_b[i][SEG-1:0], st_c[i]);
         a_d[i] = rot_in(st_a[i], r[SEG-1:0]);
         b_d[i] = rot_in(st_b[i], st_b[i][SEG-1:0]);
         c_d[i] = r[SEG];
         v_d[i] = st_v[i];
      end

      // Output stage: top segment. The carry into the MSB is recovered as
      // sum_msb ^ a_msb ^ b_msb, which gives the signed-overflow flag.
      a_seg   = st_a[NSEG-1][SEG-1:0];
      b_seg   = st_b[NSEG-1][SEG-1:0];
      r       = seg_add(a_seg, b_seg, st_c[NSEG-1]);
      sum_d   = rot_in(st_a[NSEG-1], r[SEG-1:0]);
      cout_d  = r[SEG];
      ovf_d   = r[SEG] ^ (r[SEG-1] ^ a_seg[SEG-1] ^ b_seg[SEG-1]);
      valid_d = st_v[NSEG-1];
   end

   // Pipeline registers: reset first, then load unless stalled.
   always_ff @(posedge clk) begin
      if (!reset_L) begin
         for (int i = 0; i < NPIPE; i++) begin
            a_q[i] <= '0;
            b_q[i] <= '0;
            c_q[i] <= 1'b0;
            v_q[i] <= 1'b0;
         end
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
      end else if (!stall) begin
         for (int i = 0; i < NPIPE; i++) begin
            a_q[i] <= a_d[i];
            b_q[i] <= b_d[i];
            c_q[i] <= c_d[i];
            v_q[i] <= v_d[i];
         end
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         valid_q <= valid_d;
      end else begin
         for (int i = 0; i < NPIPE; i++) begin
            a_q[i] <= a_q[i];
            b_q[i] <= b_q[i];
            c_q[i] <= c_q[i];
            v_q[i] <= v_q[i];
         end
         sum_q   <= sum_q;
         cout_q  <= cout_q;
         ovf_q   <= ovf_q;
         valid_q <= valid_q;
      end
   end

   assign out_sum   = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
   assign out_valid = valid_q;

endmodule
